// File: rtl/scan_mux_nxw_if.sv
// Channel-select bus between scan_mux_nxw and its consumer.
// The slave side is the selector; the master drives mode, select, enables and data.
interface scan_mux_nxw_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int SELW = $clog2(N);

  logic            mode;
  logic [SELW-1:0] sel;
  logic [N-1:0]    ch_en;
  logic [N*W-1:0]  din;
  logic [W-1:0]    dout;
  logic [SELW-1:0] ch_idx;
  logic [N-1:0]    ch_onehot;
  logic            valid;
  logic            tick;

  modport master (
    output mode, sel, ch_en, din,
    input  dout, ch_idx, ch_onehot, valid, tick
  );

  modport slave (
    input  mode, sel, ch_en, din,
    output dout, ch_idx, ch_onehot, valid, tick
  );
endinterface

// File: rtl/scan_mux_nxw.sv
// Registered N-channel, W-bit selector: manual select or prescaled round-robin scan.
// All outputs are registered with one cycle of latency; there is no backpressure, it updates every clk.
module scan_mux_nxw #(
  parameter int W   = 4,
  parameter int N   = 4,
  parameter int DIV = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_mux_nxw_if.slave bus
);
  localparam int SELW = $clog2(N);
  localparam int NP   = 1 << SELW;
  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DIV - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] ch_idx_q, next_idx;
  logic [W-1:0]    dout_q, dout_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic            valid_q, next_valid;
  logic            tick_q, tick_d;

  logic [SELW-1:0] scan_idx, cand;
  logic [NP-1:0]   en_pad;
  logic            step, any_en, cur_en;

  // Zero-padding makes out-of-range manual selects read as disabled.
  assign en_pad = NP'(bus.ch_en);
  assign step   = (cnt_q == CNT_MAX);
  assign any_en = |bus.ch_en;
  assign cur_en = en_pad[ch_idx_q];

  // Nearest enabled channel above ch_idx, wrapping; falls back to ch_idx itself.
  always_comb begin
    scan_idx = ch_idx_q;
    cand     = ch_idx_q;
    for (int k = N; k >= 1; k--) begin
      cand = SELW'((int'(ch_idx_q) + k) % N);
      if (en_pad[cand]) begin
        scan_idx = cand;
      end
    end
  end

  always_comb begin
    next_idx   = ch_idx_q;
    next_valid = 1'b0;
    tick_d     = 1'b0;
    cnt_d      = '0;
    if (bus.mode) begin
      cnt_d = step ? '0 : cnt_q + CNTW'(1);
      if (any_en) begin
        next_valid = 1'b1;
        if (!cur_en || step) begin
          next_idx = scan_idx;
          tick_d   = 1'b1;
          cnt_d    = '0;
        end
      end
    end else if (en_pad[bus.sel]) begin
      next_idx   = bus.sel;
      next_valid = 1'b1;
    end
  end

  always_comb begin
    dout_d   = bus.din[int'(next_idx) * W +: W];
    onehot_d = next_valid ? (N'(1) << next_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ch_idx_q <= '0;
      dout_q   <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ch_idx_q <= next_idx;
      dout_q   <= dout_d;
      onehot_q <= onehot_d;
      valid_q  <= next_valid;
      tick_q   <= tick_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.ch_idx    = ch_idx_q;
  assign bus.ch_onehot = onehot_q;
  assign bus.valid     = valid_q;
  assign bus.tick      = tick_q;
endmodule

// File: tb/tb_scan_mux_nxw.sv
// Directed bench for scan_mux_nxw: a DIV=3 instance walks through all modes, and a DIV=1 instance checks the per-cycle tick.
module tb_scan_mux_nxw;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_mux_nxw_if #(.W(4), .N(4)) ifa ();
  scan_mux_nxw_if #(.W(4), .N(4)) ifb ();

  scan_mux_nxw #(.W(4), .N(4), .DIV(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  scan_mux_nxw #(.W(4), .N(4), .DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [1:0] idx, input logic [3:0] d,
                       input logic [3:0] oh, input logic v, input logic t);
    chk({tag, ".idx"},    32'(ifa.ch_idx),    32'(idx));
    chk({tag, ".dout"},   32'(ifa.dout),      32'(d));
    chk({tag, ".onehot"}, 32'(ifa.ch_onehot), 32'(oh));
    chk({tag, ".valid"},  32'(ifa.valid),     32'(v));
    chk({tag, ".tick"},   32'(ifa.tick),      32'(t));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] idx;
    logic [3:0] dat;
    logic [1:0] mseq [4];

    ifa.mode = 1'b1; ifa.sel = 2'd0; ifa.ch_en = 4'b1111; ifa.din = 16'hDCBA;
    ifb.mode = 1'b1; ifb.sel = 2'd0; ifb.ch_en = 4'b0001; ifb.din = 16'hDCBA;

    repeat (2) cyc();
    chk_a("reset", 2'd0, 4'h0, 4'b0000, 1'b0, 1'b0);
    chk("reset_b.tick", 32'(ifb.tick), 32'd0);
    rst_n = 1'b1;

    cyc(); chk_a("first", 2'd0, 4'hA, 4'b0001, 1'b1, 1'b0);
    cyc(); chk_a("hold0", 2'd0, 4'hA, 4'b0001, 1'b1, 1'b0);

    // Full scan: each advance on the third edge, with the DIV=1 instance ticking every cycle.
    for (int i = 0; i < 4; i++) begin
      idx = 2'((i + 1) % 4);
      dat = 4'hA + 4'(idx);
      cyc(); chk_a("scan_adv", idx, dat, 4'(1 << idx), 1'b1, 1'b1);
      chk("div1.tick", 32'(ifb.tick), 32'd1);
      chk("div1.idx",  32'(ifb.ch_idx), 32'd0);
      chk("div1.dout", 32'(ifb.dout), 32'hA);
      repeat (2) begin
        cyc(); chk_a("scan_hold", idx, dat, 4'(1 << idx), 1'b1, 1'b0);
      end
    end

    // Mask 1010: channel 0 is masked so the first move is immediate.
    ifa.ch_en = 4'b1010;
    mseq[0] = 2'd1; mseq[1] = 2'd3; mseq[2] = 2'd1; mseq[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      idx = mseq[i];
      dat = 4'hA + 4'(idx);
      cyc(); chk_a("mask_adv", idx, dat, 4'(1 << idx), 1'b1, 1'b1);
      for (int h = 0; h < ((i == 3) ? 1 : 2); h++) begin
        cyc(); chk_a("mask_hold", idx, dat, 4'(1 << idx), 1'b1, 1'b0);
      end
    end

    ifa.ch_en = 4'b0010;
    cyc(); chk_a("unmask_now", 2'd1, 4'hB, 4'b0010, 1'b1, 1'b1);
    cyc(); chk_a("restart_h1", 2'd1, 4'hB, 4'b0010, 1'b1, 1'b0);
    cyc(); chk_a("restart_h2", 2'd1, 4'hB, 4'b0010, 1'b1, 1'b0);
    cyc(); chk_a("single_ch",  2'd1, 4'hB, 4'b0010, 1'b1, 1'b1);

    ifa.ch_en = 4'b0000;
    cyc(); chk_a("none_en",  2'd1, 4'hB, 4'b0000, 1'b0, 1'b0);
    cyc(); chk_a("none_en2", 2'd1, 4'hB, 4'b0000, 1'b0, 1'b0);

    ifa.mode = 1'b0; ifa.sel = 2'd2; ifa.ch_en = 4'b1111;
    cyc(); chk_a("man_sel2", 2'd2, 4'hC, 4'b0100, 1'b1, 1'b0);
    ifa.din = 16'hD5BA;
    cyc(); chk_a("man_din", 2'd2, 4'h5, 4'b0100, 1'b1, 1'b0);
    ifa.sel = 2'd3; ifa.ch_en = 4'b0111;
    cyc(); chk_a("man_masked", 2'd2, 4'h5, 4'b0000, 1'b0, 1'b0);

    ifa.ch_en = 4'b1111; ifa.din = 16'hDCBA; ifa.sel = 2'd1;
    cyc(); chk_a("man_sel1", 2'd1, 4'hB, 4'b0010, 1'b1, 1'b0);
    ifa.mode = 1'b1;
    cyc(); chk_a("to_auto_h1", 2'd1, 4'hB, 4'b0010, 1'b1, 1'b0);
    cyc(); chk_a("to_auto_h2", 2'd1, 4'hB, 4'b0010, 1'b1, 1'b0);
    cyc(); chk_a("to_auto_adv", 2'd2, 4'hC, 4'b0100, 1'b1, 1'b1);
    ifa.mode = 1'b0; ifa.sel = 2'd0;
    cyc(); chk_a("to_manual", 2'd0, 4'hA, 4'b0001, 1'b1, 1'b0);

    // Asynchronous reset between edges, then restart from channel 0.
    ifa.mode = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_a("arst_now", 2'd0, 4'h0, 4'b0000, 1'b0, 1'b0);
    cyc(); chk_a("arst_held", 2'd0, 4'h0, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(); chk_a("arst_first", 2'd0, 4'hA, 4'b0001, 1'b1, 1'b0);
    cyc(); chk_a("arst_hold",  2'd0, 4'hA, 4'b0001, 1'b1, 1'b0);
    cyc(); chk_a("arst_adv",   2'd1, 4'hB, 4'b0010, 1'b1, 1'b1);
    chk("div1_post.tick",   32'(ifb.tick),      32'd1);
    chk("div1_post.onehot", 32'(ifb.ch_onehot), 32'b0001);
    chk("div1_post.dout",   32'(ifb.dout),      32'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_mux_nxw.md
Name: scan_mux_nxw

Overview:
Parametrised, registered N-channel, W-bit selector with two modes: manual select and an automatic round-robin scan with a prescaler. It is the general successor of the fixed 4-to-1, 4-bit selector. It drives time-multiplexed outputs such as 7-segment digit scanning. It supports per-channel enable masks and emits a one-hot channel strobe plus an advance tick.

Parameters:
W, 4, data width per channel
N, 4, channel count (2..16)
DIV, 100000, prescaler period in clk cycles per scan step (>=1)
SELW (localparam), clog2(N), index width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
mode  input  1  0 = manual select, 1 = automatic scan
sel  input  SELW  manual channel index
ch_en  input  N  per-channel enable mask; bit i enables channel i
din  input  N*W  packed channel data; channel i = din[i*W +: W]
dout  output  W  registered selected data
ch_idx  output  SELW  registered current channel index
ch_onehot  output  N  registered one-hot strobe of ch_idx; all-zero when valid=0
valid  output  1  registered; 1 when ch_idx names an enabled channel
tick  output  1  registered 1-cycle pulse, high in the cycle ch_idx shows a newly advanced channel (auto mode only)

Behaviour:
- Reset (rst_n=0, async, overrides everything): dout=0, ch_idx=0, ch_onehot=0, valid=0, tick=0, prescaler=0.
- All outputs update together at the clk edge from a combinational next_idx.
  - Every cycle: dout <= din[next_idx], so din changes reach dout with 1-cycle latency.
  - ch_onehot <= (1<<next_idx) when next_valid, else 0.
- Prescaler, auto mode:
  - Counts 0..DIV-1 and wraps to 0.
  - step = (cnt == DIV-1). With DIV=1, step is high every cycle.
- Prescaler, manual mode: held at 0.
- Auto mode, next_idx:
  - If no ch_en bit is set: next_idx = ch_idx (hold), next_valid=0, dout still tracks din[ch_idx], tick=0.
  - Else if ch_en[ch_idx]=0 (current channel masked): next_idx = first enabled channel after ch_idx, searching upward modulo N. This does not wait for step; the prescaler restarts at 0 and tick=1.
  - Else if step: next_idx = first enabled channel after ch_idx, modulo N. If ch_idx is the only enabled channel, it stays at ch_idx but tick still pulses.
  - Otherwise hold.
  - Wrap-around: channel N-1 advances to the lowest enabled index.
- Manual mode:
  - If sel < N and ch_en[sel]=1: next_idx = sel, next_valid=1.
  - If sel >= N or ch_en[sel]=0: next_idx = ch_idx, next_valid=0 (ch_onehot=0), dout tracks din[ch_idx].
  - tick is always 0.
- Mode change:
  - auto->manual: the prescaler clears; sel takes effect at the first edge in manual mode.
  - manual->auto: the prescaler starts from 0 and scanning continues from the current ch_idx. The first step occurs DIV cycles later, unless ch_idx is masked, in which case the immediate-advance rule applies.
- First edge after reset, auto mode with ch_en[0]=1: ch_idx=0, valid=1, ch_onehot=...0001, dout=din[0], tick=0.
- Async reset asserted mid-scan: outputs clear immediately without waiting for clk. After deassertion, scanning restarts from channel 0 with the prescaler at 0.

Test Plan:
(All with W=4, N=4, DIV=3, din = {D,C,B,A} = {4'hD,4'hC,4'hB,4'hA}.)
- Reset: pull rst_n low between clock edges mid-scan -> dout=0, ch_idx=0, ch_onehot=0000, valid=0, tick=0 immediately; release -> next edge gives ch_idx=0, dout=A, ch_onehot=0001, valid=1.
- Auto scan, ch_en=1111 -> ch_idx holds 3 cycles each: 0,1,2,3,0; dout A,B,C,D,A; tick pulses once per 3 cycles, aligned with each index change.
- Mask, ch_en=1010 -> sequence 1,3,1,3.
  - Clear ch_en[3] while ch_idx=3 -> ch_idx=1 at the next edge with tick=1, prescaler restarted.
  - Then ch_en=0000 -> valid=0, ch_onehot=0000, ch_idx held.
- Manual, mode=0, sel=2 -> after 1 edge ch_idx=2, dout=C, ch_onehot=0100.
  - Change din C to 4'h5 -> dout=5 one cycle later.
  - sel=3 with ch_en[3]=0 -> ch_idx stays 2, valid=0, ch_onehot=0000.
- Mode switch: manual sel=1 then mode=1 -> ch_idx stays 1 for exactly 3 cycles, then advances to 2 with tick=1. mode back to 0 with sel=0 -> ch_idx=0 next edge, tick=0.
- DIV=1 build with ch_en=0001 -> ch_idx constantly 0, tick high every cycle, dout=A.
